// File: rtl/aes_stream_core.sv
// aes_stream_core: streaming AES-128 block engine (ECB / CBC / CTR).
// One 128-bit block is in flight at a time. The operand is registered on
// accept and held for PIPE_STAGES cycles so the combinational cipher can be
// constrained as a multicycle path. The result is captured at the end of
// that window.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   cfg_*              config bank (key, mode, direction, IV), latched on cfg_load
//   in_valid/in_ready  input block handshake (in_data, in_last)
//   out_valid/out_ready result handshake (out_data, out_last)
//   busy               engine not idle
//   cfg_err            one-cycle pulse when a cfg_load is rejected
module aes_stream_core #(
  parameter int PIPE_STAGES = 2,
  parameter int CTR_WIDTH   = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_load,
  input  logic [1:0]   cfg_mode,
  input  logic         cfg_decrypt,
  input  logic [127:0] cfg_key,
  input  logic [127:0] cfg_iv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         cfg_err
);
  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;
  localparam logic [1:0] M_ECB = 2'd0, M_CBC = 2'd1, M_CTR = 2'd2, M_RSV = 2'd3;
  localparam logic [3:0] CNT_INIT = 4'(PIPE_STAGES - 1);
  // Only the low CTR_WIDTH bits of the counter block take part in the increment.
  localparam logic [127:0] CTR_MASK = (128'd1 << CTR_WIDTH) - 128'd1;

  // ---- GF(2^8) / AES primitives ----
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction
  // a^254 == a^-1 in GF(2^8); 0 maps to 0 as AES requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, s;
    r = 8'h01; s = a;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] isbox(input logic [7:0] a);
    return ginv(rl(a, 1) ^ rl(a, 3) ^ rl(a, 6) ^ 8'h05);
  endfunction
  // Byte n of the state sits at [127-8n -: 8]; byte 4c+r is row r, column c.
  function automatic logic [127:0] sub_shift(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? ((c - r) & 3) : ((c + r) & 3);
        o[127-8*(4*c+r) -: 8] = inv ? isbox(s[127-8*(4*src+r) -: 8])
                                    : sbox(s[127-8*(4*src+r) -: 8]);
      end
    return o;
  endfunction
  function automatic logic [127:0] mix(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [31:0]  cf;
    logic [7:0]   b;
    cf = inv ? 32'h0e0b0d09 : 32'h02030101;
    o  = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++)
          b ^= gmul(s[127-8*(4*c+j) -: 8], cf[31-8*((j-r)&3) -: 8]);
        o[127-8*(4*c+r) -: 8] = b;
      end
    return o;
  endfunction
  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s, rk;
    logic [7:0]   rc;
    rk = key; rc = 8'h01; s = pt ^ key;
    for (int r = 1; r <= 10; r++) begin
      rk = next_key(rk, rc);
      rc = xt(rc);
      s  = sub_shift(s, 1'b0);
      if (r != 10) s = mix(s, 1'b0);
      s ^= rk;
    end
    return s;
  endfunction
  function automatic logic [127:0] aes_dec(input logic [127:0] ct, input logic [127:0] key);
    logic [127:0] rks [11];
    logic [127:0] s;
    logic [7:0]   rc;
    rks[0] = key; rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      rks[r] = next_key(rks[r-1], rc);
      rc     = xt(rc);
    end
    s = ct ^ rks[10];
    for (int r = 9; r >= 0; r--) begin
      s  = sub_shift(s, 1'b1);
      s ^= rks[r];
      if (r != 0) s = mix(s, 1'b1);
    end
    return s;
  endfunction

  // ---- state ----
  state_t       state, state_n;
  logic [3:0]   cnt;
  logic [1:0]   mode_q;
  logic         dec_q, last_q, cfg_ok, accept, use_dec;
  logic [127:0] key_q, iv_q, chain_q, ctr_q, in_q, op_q;
  logic [127:0] op_sel, enc_r, dec_r, res, ctr_inc;

  always_comb begin
    state_n   = state;
    in_ready  = (state == IDLE) && !cfg_load;  // a config write takes the cycle
    out_valid = (state == OUT);
    busy      = (state != IDLE);
    cfg_ok    = cfg_load && (state == IDLE) && (cfg_mode != M_RSV);
    accept    = in_valid && in_ready;
    case (state)
      IDLE:    if (accept) state_n = CALC;
      CALC:    if (cnt == 4'd0) state_n = OUT;
      OUT:     if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand presented to the cipher core, chosen at accept time.
  always_comb begin
    op_sel = in_data;
    if (mode_q == M_CBC && !dec_q) op_sel = in_data ^ chain_q;
    else if (mode_q == M_CTR)      op_sel = ctr_q;
  end

  // CTR always runs the forward cipher, whatever the direction bit says.
  assign use_dec = dec_q && (mode_q != M_CTR);
  assign enc_r   = aes_enc(op_q, key_q);
  assign dec_r   = aes_dec(op_q, key_q);
  assign ctr_inc = ((ctr_q + 128'd1) & CTR_MASK) | (ctr_q & ~CTR_MASK);

  always_comb begin
    res = use_dec ? dec_r : enc_r;
    if (mode_q == M_CBC && dec_q) res = dec_r ^ chain_q;
    else if (mode_q == M_CTR)     res = enc_r ^ in_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      mode_q   <= M_ECB;
      dec_q    <= 1'b0;
      key_q    <= '0;
      iv_q     <= '0;
      chain_q  <= '0;
      ctr_q    <= '0;
      in_q     <= '0;
      op_q     <= '0;
      last_q   <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state   <= state_n;
      cfg_err <= cfg_load && !cfg_ok;
      if (cfg_ok) begin
        mode_q  <= cfg_mode;
        dec_q   <= cfg_decrypt;
        key_q   <= cfg_key;
        iv_q    <= cfg_iv;
        chain_q <= cfg_iv;
        ctr_q   <= cfg_iv;
      end
      if (state == IDLE && accept) begin
        in_q   <= in_data;
        last_q <= in_last;
        op_q   <= op_sel;
        cnt    <= CNT_INIT;
      end
      if (state == CALC) begin
        if (cnt == 4'd0) begin
          out_data <= res;
          out_last <= last_q;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
      if (state == OUT && out_ready) begin
        if (out_last) begin
          // end of message: next block restarts chaining from the IV
          chain_q <= iv_q;
          ctr_q   <= iv_q;
        end else if (mode_q == M_CBC) begin
          chain_q <= dec_q ? in_q : out_data;
        end else if (mode_q == M_CTR) begin
          ctr_q <= ctr_inc;
        end
      end
    end
  end
endmodule

// File: tb/tb_aes_stream_core.sv
module tb_aes_stream_core;
  localparam int PIPE = 2;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PTF = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CTF = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] IVC = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] R1  = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] R2  = 128'h9806f66b7970fdff8617187bb9fffdff;
  localparam logic [127:0] Z0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;  // E_0(0)
  localparam logic [127:0] IVW = {96'h0, 32'hffffffff};

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         cfg_load = 1'b0, cfg_decrypt = 1'b0;
  logic [1:0]   cfg_mode = 2'd0;
  logic [127:0] cfg_key = '0, cfg_iv = '0, in_data = '0;
  logic         in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic         in_ready, out_valid, out_last, busy, cfg_err;
  logic [127:0] out_data;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  aes_stream_core #(.PIPE_STAGES(PIPE), .CTR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_mode(cfg_mode),
    .cfg_decrypt(cfg_decrypt), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .cfg_err(cfg_err)
  );

  typedef struct {
    logic         do_cfg;
    logic [1:0]   mode;
    logic         dec;
    logic [127:0] key;
    logic [127:0] iv;
    logic [127:0] din;
    logic         last;
    logic         chk;
    logic [127:0] exp;
  } vec_t;
  vec_t tv [15];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_cfg(input logic [1:0] m, input logic d, input logic [127:0] k,
                        input logic [127:0] iv);
    @(negedge clk);
    cfg_load = 1'b1; cfg_mode = m; cfg_decrypt = d; cfg_key = k; cfg_iv = iv;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic send(input string nm, input logic [127:0] d, input logic l);
    int g;
    g = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    #1;
    while (in_ready !== 1'b1 && g < 50) begin
      @(negedge clk); #1; g++;
    end
    if (g >= 50) chk({nm, "_accept_timeout"}, 128'(g), 128'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for the result, check latency / data / last, then hand it off.
  task automatic collect(input string nm, input logic [127:0] exp, input logic exp_last,
                         input logic chk_data, input int exp_lat);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1; lat++;
    end
    chk({nm, "_latency"}, 128'(lat), 128'(exp_lat));
    if (chk_data) chk({nm, "_data"}, out_data, exp);
    chk({nm, "_last"}, 128'(out_last), 128'(exp_last));
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] held;
    //            cfg   mode   dec   key  iv   din  last chk  exp
    tv[0]  = '{1'b1, 2'd0, 1'b0, K1, '0,  PTF, 1'b0, 1'b1, CTF};
    tv[1]  = '{1'b1, 2'd0, 1'b1, K1, '0,  CTF, 1'b0, 1'b1, PTF};
    tv[2]  = '{1'b1, 2'd1, 1'b0, K2, K1,  P1,  1'b0, 1'b1, C1};
    tv[3]  = '{1'b0, 2'd1, 1'b0, K2, K1,  P2,  1'b1, 1'b1, C2};
    tv[4]  = '{1'b1, 2'd1, 1'b1, K2, K1,  C1,  1'b0, 1'b1, P1};
    tv[5]  = '{1'b0, 2'd1, 1'b1, K2, K1,  C2,  1'b1, 1'b1, P2};
    tv[6]  = '{1'b1, 2'd2, 1'b0, K2, IVC, P1,  1'b0, 1'b1, R1};
    tv[7]  = '{1'b0, 2'd2, 1'b0, K2, IVC, P2,  1'b1, 1'b1, R2};
    tv[8]  = '{1'b1, 2'd2, 1'b1, K2, IVC, R1,  1'b0, 1'b1, P1};
    tv[9]  = '{1'b0, 2'd2, 1'b1, K2, IVC, R2,  1'b1, 1'b1, P2};
    tv[10] = '{1'b1, 2'd1, 1'b0, K2, K1,  P1,  1'b1, 1'b1, C1};
    tv[11] = '{1'b0, 2'd1, 1'b0, K2, K1,  P1,  1'b1, 1'b1, C1};
    // counter low word wraps to 0 with no carry into the upper 96 bits
    tv[12] = '{1'b1, 2'd2, 1'b0, '0,  IVW, '0,  1'b0, 1'b0, '0};
    tv[13] = '{1'b0, 2'd2, 1'b0, '0,  IVW, '0,  1'b1, 1'b1, Z0};
    tv[14] = '{1'b1, 2'd0, 1'b0, '0,  '0,  '0,  1'b0, 1'b1, Z0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy",      128'(busy),      128'd0);
    chk("rst_cfg_err",   128'(cfg_err),   128'd0);
    chk("rst_out_data",  out_data,        128'd0);
    chk("rst_out_last",  128'(out_last),  128'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("idle_in_ready", 128'(in_ready), 128'd1);

    for (int i = 0; i < 15; i++) begin
      if (tv[i].do_cfg) begin
        do_cfg(tv[i].mode, tv[i].dec, tv[i].key, tv[i].iv);
        chk($sformatf("vec%0d_cfg_err", i), 128'(cfg_err), 128'd0);
      end
      send($sformatf("vec%0d", i), tv[i].din, tv[i].last);
      collect($sformatf("vec%0d", i), tv[i].exp, tv[i].last, tv[i].chk, PIPE);
    end

    // cfg_load while computing: rejected, config and chain untouched
    do_cfg(2'd1, 1'b0, K2, K1);
    send("calc_cfg", P1, 1'b0);
    @(negedge clk);
    cfg_load = 1'b1; cfg_mode = 2'd0; cfg_decrypt = 1'b1; cfg_key = K1; cfg_iv = '0;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    chk("calc_cfg_err_pulse", 128'(cfg_err), 128'd1);
    @(posedge clk); #1;
    chk("calc_cfg_err_clear", 128'(cfg_err), 128'd0);
    collect("calc_cfg_b1", C1, 1'b0, 1'b1, 0);
    send("calc_cfg_b2", P2, 1'b1);
    collect("calc_cfg_b2", C2, 1'b1, 1'b1, PIPE);

    // reserved mode rejected in IDLE; in_ready drops while cfg_load is up
    @(negedge clk);
    cfg_load = 1'b1; cfg_mode = 2'd3; cfg_decrypt = 1'b0; cfg_key = K1; cfg_iv = '0;
    #1 chk("rsv_in_ready", 128'(in_ready), 128'd0);
    @(posedge clk); #1;
    cfg_load = 1'b0;
    chk("rsv_cfg_err", 128'(cfg_err), 128'd1);
    send("rsv_after", P1, 1'b1);
    collect("rsv_after", C1, 1'b1, 1'b1, PIPE);

    // cfg_load and in_valid together: config first, block next cycle
    @(negedge clk);
    cfg_load = 1'b1; cfg_mode = 2'd0; cfg_decrypt = 1'b0; cfg_key = K1; cfg_iv = '0;
    in_valid = 1'b1; in_data = PTF; in_last = 1'b0;
    #1 chk("both_in_ready_lo", 128'(in_ready), 128'd0);
    @(posedge clk); #1;
    cfg_load = 1'b0;
    chk("both_cfg_err", 128'(cfg_err), 128'd0);
    #1 chk("both_in_ready_hi", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    collect("both", CTF, 1'b0, 1'b1, PIPE);

    // downstream stall for 10 cycles
    out_ready = 1'b0;
    send("stall", PTF, 1'b1);
    collect("stall", CTF, 1'b1, 1'b1, PIPE);
    held = CTF;
    @(negedge clk);
    in_valid = 1'b1; in_data = P1; in_last = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_valid", c), 128'(out_valid), 128'd1);
      chk($sformatf("stall%0d_data", c), out_data, held);
      chk($sformatf("stall%0d_in_ready", c), 128'(in_ready), 128'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_busy", 128'(busy), 128'd0);

    // reset while computing: block discarded, key/mode back to zero / ECB enc
    send("rst_mid", P1, 1'b0);
    chk("rst_mid_busy", 128'(busy), 128'd1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 128'(out_valid), 128'd0);
    chk("rst_mid_busy_lo",   128'(busy),      128'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rst_mid_in_ready", 128'(in_ready), 128'd1);
    send("post_rst", '0, 1'b0);
    collect("post_rst", Z0, 1'b0, 1'b1, PIPE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
